// File: rtl/packet_serializer.sv
// Frames a DATA_BYTES payload as commas, data and optional EOP, then shifts it out as 9-bit symbols MSB first.
// First packet bit 1..9 cycles after handshake; ready_o drops while the single holding entry is full.
module packet_serializer #(
    parameter int          DATA_BYTES = 3,
    parameter int          SYNC_SYMS  = 1,
    parameter int          EOP_EN     = 1,
    parameter logic [7:0]  COMMA      = 8'h3C,
    parameter logic [7:0]  EOP_CODE   = 8'hFD
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [8*DATA_BYTES-1:0] data_i,
    output logic                    data_o,
    output logic                    sym_last_o,
    output logic                    busy_o,
    output logic                    eot_o
);

    localparam int PKT_SYMS = SYNC_SYMS + DATA_BYTES + EOP_EN;
    localparam int SW       = $clog2(PKT_SYMS + 1);

    localparam logic [SW-1:0] LAST_SYM  = SW'(PKT_SYMS - 1);
    localparam logic [SW-1:0] SYNC_END  = SW'(SYNC_SYMS);
    localparam logic [SW-1:0] DATA_END  = SW'(SYNC_SYMS + DATA_BYTES);
    localparam logic [8:0]    COMMA_SYM = {1'b1, COMMA};
    localparam logic [8:0]    EOP_SYM   = {1'b1, EOP_CODE};

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_nxt;
    logic [8:0]              shreg, shreg_nxt;
    logic [3:0]              bit_cnt;
    logic [SW-1:0]           sym_cnt, sym_cnt_nxt, nidx;
    logic                    pending, start_pkt, eot, eot_nxt;
    logic [8*DATA_BYTES-1:0] hold, work;
    logic [7:0]              byte_sel;
    logic                    boundary, handshake;

    assign boundary  = (bit_cnt == 4'd8);
    assign handshake = valid_i && !pending;

    assign data_o     = shreg[8];
    assign sym_last_o = boundary;
    assign busy_o     = (state == SEND);
    assign eot_o      = eot;
    assign ready_o    = !pending;

    always_comb begin
        nidx     = sym_cnt + SW'(1);
        byte_sel = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (nidx == SW'(SYNC_SYMS + i)) begin
                byte_sel = work[8*i +: 8];
            end
        end
    end

    // Packet symbol 0 is always a comma (at least one sync symbol), so a
    // packet start never needs the payload on the same edge it is copied.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = {shreg[7:0], 1'b0};
        sym_cnt_nxt = sym_cnt;
        start_pkt   = 1'b0;
        eot_nxt     = 1'b0;
        if (boundary) begin
            if (state == IDLE) begin
                shreg_nxt = COMMA_SYM;
                if (pending) begin
                    start_pkt   = 1'b1;
                    sym_cnt_nxt = '0;
                    state_nxt   = SEND;
                end
            end else if (sym_cnt < LAST_SYM) begin
                sym_cnt_nxt = nidx;
                if (nidx < SYNC_END) begin
                    shreg_nxt = COMMA_SYM;
                end else if (nidx < DATA_END) begin
                    shreg_nxt = {1'b0, byte_sel};
                end else begin
                    shreg_nxt = EOP_SYM;
                end
            end else begin
                eot_nxt     = 1'b1;
                shreg_nxt   = COMMA_SYM;
                sym_cnt_nxt = '0;
                if (pending) begin
                    start_pkt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg   <= COMMA_SYM;
            bit_cnt <= '0;
            sym_cnt <= '0;
            pending <= 1'b0;
            hold    <= '0;
            work    <= '0;
            eot     <= 1'b0;
        end else begin
            shreg   <= shreg_nxt;
            bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;
            sym_cnt <= sym_cnt_nxt;
            eot     <= eot_nxt;
            if (handshake) begin
                hold    <= data_i;
                pending <= 1'b1;
            end else if (start_pkt) begin
                pending <= 1'b0;
            end
            if (start_pkt) begin
                work <= hold;
            end
        end
    end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: default instance u0 plus a 1-byte/2-sync/no-EOP instance u1.
module tb_packet_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic [23:0] data0 = '0;
    logic [7:0]  data1 = '0;
    logic        ready0, so0, last0, busy0, eot0;
    logic        ready1, so1, last1, busy1, eot1;

    packet_serializer u0 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid0), .ready_o(ready0), .data_i(data0),
        .data_o(so0), .sym_last_o(last0), .busy_o(busy0), .eot_o(eot0)
    );

    packet_serializer #(.DATA_BYTES(1), .SYNC_SYMS(2), .EOP_EN(0)) u1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid1), .ready_o(ready1), .data_i(data1),
        .data_o(so1), .sym_last_o(last1), .busy_o(busy1), .eot_o(eot1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    logic lg_d [2][2048];
    logic lg_l [2][2048];
    logic lg_b [2][2048];
    logic lg_e [2][2048];

    int P_SYNC [2] = '{1, 2};
    int P_DB   [2] = '{3, 1};
    int P_EOP  [2] = '{1, 0};

    // Model: current symbol, bit position in it, remaining framed symbols, one-deep holding slot.
    int           ph    [2];
    logic [8:0]   cur   [2];
    bit           inpkt [2];
    bit           hv    [2];
    bit           eotf  [2];
    logic [127:0] hd    [2];
    logic [8:0]   fr    [2][21];
    int           flen  [2];
    int           fpos  [2];

    task automatic chk1(string nm, int u, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d cyc=%0d actual=%b expected=%b", nm, u, cyc, act, exp);
        end
    endtask

    task automatic chkv(string nm, int u, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d cyc=%0d actual=%0h expected=%0h", nm, u, cyc, act, exp);
        end
    endtask

    task automatic mreset(int u);
        ph[u] = 0; cur[u] = 9'h13C; inpkt[u] = 0; hv[u] = 0; eotf[u] = 0;
        flen[u] = 0; fpos[u] = 0; hd[u] = '0;
    endtask

    task automatic build(int u, logic [127:0] d);
        int n = 0;
        for (int s = 0; s < P_SYNC[u]; s++) begin fr[u][n] = 9'h13C; n++; end
        for (int b = 0; b < P_DB[u]; b++) begin fr[u][n] = {1'b0, d[8*b +: 8]}; n++; end
        if (P_EOP[u] == 1) begin fr[u][n] = 9'h1FD; n++; end
        flen[u] = n;
    endtask

    task automatic mcheck(int u, logic d, logic l, logic b, logic r, logic e);
        chk1("data", u, d, cur[u][8-ph[u]]);
        chk1("sym_last", u, l, ph[u] == 8);
        chk1("busy", u, b, inpkt[u]);
        chk1("ready", u, r, !hv[u]);
        chk1("eot", u, e, eotf[u]);
    endtask

    task automatic mstep(int u, logic v, logic [127:0] d);
        bit hs = v && !hv[u];
        bit ne = 0;
        if (ph[u] == 8) begin
            if (inpkt[u] && fpos[u] < flen[u]) begin
                cur[u] = fr[u][fpos[u]];
                fpos[u]++;
            end else begin
                if (inpkt[u]) ne = 1;
                if (hv[u]) begin
                    build(u, hd[u]);
                    cur[u] = fr[u][0]; fpos[u] = 1; inpkt[u] = 1; hv[u] = 0;
                end else begin
                    cur[u] = 9'h13C; inpkt[u] = 0;
                end
            end
            ph[u] = 0;
        end else begin
            ph[u]++;
        end
        eotf[u] = ne;
        if (hs) begin hv[u] = 1; hd[u] = d; end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin mreset(0); mreset(1); end
        mcheck(0, so0, last0, busy0, ready0, eot0);
        mcheck(1, so1, last1, busy1, ready1, eot1);
        if (cyc < 2048) begin
            lg_d[0][cyc] = so0; lg_l[0][cyc] = last0; lg_b[0][cyc] = busy0; lg_e[0][cyc] = eot0;
            lg_d[1][cyc] = so1; lg_l[1][cyc] = last1; lg_b[1][cyc] = busy1; lg_e[1][cyc] = eot1;
        end
        if (!rst) begin
            mstep(0, valid0, {104'd0, data0});
            mstep(1, valid1, {120'd0, data1});
        end
    end

    function automatic logic [63:0] bits(int u, int start, int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], lg_d[u][start+i]};
        return r;
    endfunction

    function automatic int first_busy(int u, int from);
        for (int i = from; i < from + 60; i++) if (lg_b[u][i]) return i;
        return -1;
    endfunction

    function automatic int busy_run(int u, int s);
        int n = 0;
        while (n < 300 && lg_b[u][s+n]) n++;
        return n;
    endfunction

    function automatic int eot_count(int u, int s, int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (lg_e[u][i]) c++;
        return c;
    endfunction

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic align0(int p);
        int k = 0;
        @(negedge clk);
        while (!last0 && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #2;
        tick(p);
    endtask

    task automatic send(int u, logic [23:0] d, output int hc);
        int k = 0;
        hc = -1;
        if (u == 0) begin data0 = d; valid0 = 1'b1; end
        else begin data1 = d[7:0]; valid1 = 1'b1; end
        while (k < 300) begin
            @(negedge clk);
            if ((u == 0 ? ready0 : ready1) == 1'b1) begin hc = cyc; break; end
            k++;
        end
        @(posedge clk); #2;
        if (u == 0) valid0 = 1'b0; else valid1 = 1'b0;
        if (hc < 0) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout u%0d cyc=%0d actual=no_ready expected=ready", u, cyc);
            hc = cyc;
        end
    endtask

    task automatic start_of(int u, int h, output int s);
        s = first_busy(u, h);
        chk1("start_latency", u, (s - h >= 1) && (s - h <= 9), 1'b1);
        if (s < 0) s = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, h, h1, h2, h3, s;

        // Reset and idle line
        tick(3);
        rst = 1'b0;
        rc = cyc;
        tick(40);
        chkv("idle_line", 0, bits(0, rc, 36), {28'd0, {4{9'h13C}}});
        chk1("idle_last_ph7", 0, lg_l[0][rc+7], 1'b0);
        chk1("idle_last_ph8", 0, lg_l[0][rc+8], 1'b1);
        chkv("idle_no_eot", 0, eot_count(0, rc, 40), 0);

        // Single packet, handshake at bit 3
        align0(3);
        send(0, 24'hC3A55A, h);
        tick(60);
        chk1("p1_busy_pre", 0, lg_b[0][h+5], 1'b0);
        chk1("p1_busy_first", 0, lg_b[0][h+6], 1'b1);
        chkv("p1_line", 0, bits(0, h+6, 45), {19'd0, 9'h13C, 9'h05A, 9'h0A5, 9'h0C3, 9'h1FD});
        chkv("p1_busy_len", 0, busy_run(0, h+6), 45);
        chk1("p1_eot_pre", 0, lg_e[0][h+50], 1'b0);
        chk1("p1_eot", 0, lg_e[0][h+51], 1'b1);
        chk1("p1_eot_post", 0, lg_e[0][h+52], 1'b0);
        chkv("p1_after", 0, bits(0, h+51, 9), 64'h13C);

        // Back-to-back
        send(0, 24'h0A0B0C, h1);
        send(0, 24'h030201, h2);
        tick(100);
        start_of(0, h1, s);
        chkv("b2b_hs_cycle", 0, h2, s);
        chkv("b2b_busy_len", 0, busy_run(0, s), 90);
        chk1("b2b_eot1", 0, lg_e[0][s+45], 1'b1);
        chk1("b2b_eot2", 0, lg_e[0][s+90], 1'b1);
        chkv("b2b_eot_cnt", 0, eot_count(0, s, 95), 2);
        chkv("b2b_seam", 0, bits(0, s+36, 18), {46'd0, 9'h1FD, 9'h13C});
        chkv("b2b_p2_data", 0, bits(0, s+54, 27), {37'd0, 9'h001, 9'h002, 9'h003});

        // Backpressure: valid held with other data while the slot is full
        send(0, 24'h445566, h1);
        send(0, 24'h778899, h2);
        valid0 = 1'b1;
        data0  = 24'h5A5A5A;
        tick(20);
        send(0, 24'hDDEEFF, h3);
        tick(150);
        start_of(0, h1, s);
        chkv("bp_busy_len", 0, busy_run(0, s), 135);
        chkv("bp_eot_cnt", 0, eot_count(0, s, 140), 3);
        chkv("bp_p1_data", 0, bits(0, s+9, 27), {37'd0, 9'h066, 9'h055, 9'h044});
        chkv("bp_p2_data", 0, bits(0, s+54, 27), {37'd0, 9'h099, 9'h088, 9'h077});
        chkv("bp_p3_data", 0, bits(0, s+99, 27), {37'd0, 9'h0FF, 9'h0EE, 9'h0DD});
        chk1("bp_p3_hs_late", 0, h3 > h2 + 20, 1'b1);

        // Parameter variant
        send(1, 24'h00007E, h);
        tick(40);
        start_of(1, h, s);
        chkv("sw_line", 1, bits(1, s, 27), {37'd0, 9'h13C, 9'h13C, 9'h07E});
        chkv("sw_busy_len", 1, busy_run(1, s), 27);
        chk1("sw_eot", 1, lg_e[1][s+27], 1'b1);

        // Reset during data symbol 1
        send(0, 24'hF0E1D2, h);
        tick(12);
        start_of(0, h, s);
        while (cyc < s + 20) tick(1);
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_data", 0, so0, 1'b1);
        chk1("rst_ready", 0, ready0, 1'b1);
        chk1("rst_busy", 0, busy0, 1'b0);
        chk1("rst_last", 0, last0, 1'b0);
        chk1("rst_eot", 0, eot0, 1'b0);
        tick(3);
        rst = 1'b0;
        rc = cyc;
        tick(40);
        chkv("rst_line", 0, bits(0, rc, 36), {28'd0, {4{9'h13C}}});
        chkv("rst_no_busy", 0, busy_run(0, rc), 0);
        chkv("rst_no_eot", 0, eot_count(0, rc, 40), 0);
        chk1("rst_ready_after", 0, ready0, 1'b1);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Parametrised 9-bit-symbol framer and bit serializer. Symbol format is {k, byte[7:0]}, where k=1 marks a control code.
- Accepts a DATA_BYTES-wide payload through a valid/ready handshake and frames it as SYNC_SYMS comma symbols, then DATA_BYTES data symbols, then an optional EOP control symbol.
- Shifts the framed packet out one bit per clock and fills the line with commas when idle.
- Sits between the packet source and the serial link PHY and replaces fixed-size, start-pulse framing.

Parameters:
- DATA_BYTES, 3: payload bytes per packet; legal range 1..16.
- SYNC_SYMS, 1: comma symbols sent before the payload; legal range 1..4.
- EOP_EN, 1: 1 appends an EOP control symbol after the payload; 0 omits it.
- COMMA, 8'h3C: comma/idle code, always sent with k=1.
- EOP_CODE, 8'hFD: end-of-packet code, sent with k=1.
- Derived: PKT_SYMS = SYNC_SYMS + DATA_BYTES + EOP_EN.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  payload valid.
- ready_o  out  1  holding register empty; handshake completes when valid_i && ready_o at a rising edge.
- data_i  in  8*DATA_BYTES  payload; byte n is data_i[8n+7:8n].
- data_o  out  1  serial bit, driven directly from shift-register bit 8.
- sym_last_o  out  1  high during the last bit (bit 0) of every symbol.
- busy_o  out  1  high while a packet symbol is on the line (state SEND).
- eot_o  out  1  one-cycle pulse after the final packet symbol.

Behaviour:
- Reset (async assert): shift reg = {1, COMMA}; bit_cnt = 0; sym_cnt = 0; state = IDLE; pending = 0.
  - Outputs during reset: data_o = 1, ready_o = 1, sym_last_o = 0, busy_o = 0, eot_o = 0.
  - A reset mid-packet discards the holding register, the working register and the partial packet. Line restarts with a fresh comma.
- Bit timing:
  - Each symbol occupies exactly 9 cycles, MSB first: k, then b7..b0.
  - bit_cnt counts 0..8 and wraps to 0. sym_last_o = (bit_cnt == 8).
  - The shift register shifts left every cycle. When bit_cnt == 8 (symbol boundary) it loads the next symbol instead.
- Holding register:
  - Single entry. It captures data_i on handshake and sets pending.
  - ready_o = !pending. ready_o must not depend combinationally on valid_i.
- States:
  - IDLE: at each boundary, if pending = 0, load {1, COMMA}.
    - If pending = 1: copy the holding register into the working register, clear pending, load packet symbol 0, set sym_cnt = 0, go to SEND.
    - ready_o therefore rises the cycle after the packet starts.
  - SEND: at each boundary, if sym_cnt < PKT_SYMS-1, increment sym_cnt and load packet symbol sym_cnt+1.
    - On the boundary of the final symbol, pulse eot_o (registered, high during the following cycle).
    - Then, if pending = 1, start the next packet immediately (back-to-back, no comma gap), as in IDLE.
    - Otherwise load a comma and go to IDLE.
- Packet symbol index s:
  - s < SYNC_SYMS: {1, COMMA}.
  - s < SYNC_SYMS + DATA_BYTES: {0, byte(s - SYNC_SYMS)}, byte 0 first.
  - Otherwise: {1, EOP_CODE}.
- Pending timing: the boundary decision uses the registered pending. A handshake on a boundary cycle is therefore not eligible until the next boundary.
  - Start latency after handshake is 1..9 cycles to the first packet bit.
- Simultaneous events: a handshake in the same cycle that pending clears cannot occur, because ready_o was 0 in that cycle.
  - A handshake in the cycle after a packet starts is legal and buffers the next packet.
- busy_o is high from the first bit of packet symbol 0 through the last bit of the final symbol.
- Packet length on the line is 9*PKT_SYMS cycles; the default is 45.

Test Plan:
- Reset and idle: no valid_i for 40 cycles after reset release.
  - data_o repeats the pattern 1,0,0,1,1,1,1,0,0 (0x13C).
  - sym_last_o every 9th cycle; ready_o = 1; busy_o = 0; eot_o = 0.
- Single packet, defaults: data_i = 24'hC3A55A, handshake at bit_cnt = 3.
  - First packet bit after 6 cycles.
  - Line carries 0x13C, 0x05A, 0x0A5, 0x0C3, 0x1FD (45 cycles), then commas.
  - eot_o high exactly 1 cycle, on the first idle-comma bit.
- Back-to-back: second handshake (24'h030201) the cycle ready_o rises during packet 1.
  - Packet 2's comma follows the packet 1 EOP with no gap.
  - Two eot_o pulses 45 cycles apart; busy_o stays high for 90 cycles.
- Backpressure: hold valid_i high while pending = 1.
  - ready_o = 0 and the holding content stays unchanged until packet start.
  - No payload is lost or duplicated.
- Parameter sweep: DATA_BYTES = 1, SYNC_SYMS = 2, EOP_EN = 0, data_i = 8'h7E.
  - Line carries 0x13C, 0x13C, 0x07E (27 cycles), then eot_o.
- Reset mid-packet: assert rst_i during data symbol 1.
  - Outputs go to reset values immediately.
  - After release, the line shows only commas, no leftover payload, and ready_o = 1.
